// File: rtl/reg_dispatch_ctrl.sv
// reg_dispatch_ctrl: register-read / dispatch stage with a busy scoreboard, writeback bypass
// and local retirement of direct register assignments.
module reg_dispatch_ctrl #(
    parameter int LANES    = 2,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int WB_PORTS = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [LANES-1:0]           in_valid_i,
    output logic [LANES-1:0]           in_ready_o,
    input  logic [LANES-1:0]           pwrite_i,
    input  logic [LANES-1:0]           pread_i,
    input  logic [LANES-1:0]           sread_i,
    input  logic [2*LANES-1:0]         functype_i,
    input  logic [7*LANES-1:0]         opcode_i,
    input  logic [ADDR_W*LANES-1:0]    prim_addr_i,
    input  logic [DATA_W*LANES-1:0]    sec_i,
    output logic [LANES-1:0]           out_valid_o,
    input  logic [LANES-1:0]           out_ready_i,
    output logic [LANES-1:0]           out_wb_o,
    output logic [7*LANES-1:0]         out_opcode_o,
    output logic [2*LANES-1:0]         out_functype_o,
    output logic [ADDR_W*LANES-1:0]    out_rd_o,
    output logic [DATA_W*LANES-1:0]    out_prim_o,
    output logic [DATA_W*LANES-1:0]    out_sec_o,
    input  logic [WB_PORTS-1:0]        wb_en_i,
    input  logic [ADDR_W*WB_PORTS-1:0] wb_addr_i,
    input  logic [DATA_W*WB_PORTS-1:0] wb_data_i
);
    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0]       regs_q [NREGS];
    logic [DATA_W-1:0]       regs_d [NREGS];
    logic [DATA_W-1:0]       rd_val [NREGS];
    logic [NREGS-1:0]        busy_q, busy_d, wb_hit, pend, dest_mask;
    logic [LANES-1:0]        out_valid_q, out_valid_d, out_wb_q, out_wb_d;
    logic [7*LANES-1:0]      out_opcode_q, out_opcode_d;
    logic [2*LANES-1:0]      out_functype_q, out_functype_d;
    logic [ADDR_W*LANES-1:0] out_rd_q, out_rd_d;
    logic [DATA_W*LANES-1:0] out_prim_q, out_prim_d, out_sec_q, out_sec_d;
    logic                    chain, haz, acc, asg;
    logic [ADDR_W-1:0]       pa, sa;
    logic [DATA_W-1:0]       prim_v, sec_v;

    // Register view with this cycle's writebacks applied; later ports override earlier ones.
    always_comb begin
        wb_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            rd_val[r] = regs_q[r];
            for (int p = 0; p < WB_PORTS; p++)
                if (wb_en_i[p] && wb_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rd_val[r] = wb_data_i[p*DATA_W +: DATA_W];
                    wb_hit[r] = 1'b1;
                end
        end
        pend = busy_q & ~wb_hit;
    end

    always_comb begin
        regs_d         = rd_val;
        busy_d         = busy_q & ~wb_hit;
        out_valid_d    = out_valid_q;
        out_wb_d       = out_wb_q;
        out_opcode_d   = out_opcode_q;
        out_functype_d = out_functype_q;
        out_rd_d       = out_rd_q;
        out_prim_d     = out_prim_q;
        out_sec_d      = out_sec_q;
        in_ready_o     = '0;
        dest_mask      = '0;
        chain          = reset_i && !flush_i;
        pa = '0; sa = '0; haz = 1'b0; acc = 1'b0; asg = 1'b0; prim_v = '0; sec_v = '0;
        for (int k = 0; k < LANES; k++)
            if (flush_i && out_valid_q[k] && out_wb_q[k])
                busy_d[out_rd_q[k*ADDR_W +: ADDR_W]] = 1'b0;
        // Lanes are visited oldest first so set-after-clear and in-order acceptance fall out naturally.
        for (int k = 0; k < LANES; k++) begin
            pa     = prim_addr_i[k*ADDR_W +: ADDR_W];
            sa     = sec_i[k*DATA_W +: ADDR_W];
            haz    = ((pread_i[k] || pwrite_i[k]) && (pend[pa] || dest_mask[pa])) ||
                     (sread_i[k] && (pend[sa] || dest_mask[sa]));
            acc    = chain && in_valid_i[k] && (!out_valid_q[k] || out_ready_i[k]) && !haz;
            chain  = chain && (acc || !in_valid_i[k]);
            asg    = functype_i[k*2 +: 2] == 2'd1 && opcode_i[k*7 +: 7] == 7'd10 && pwrite_i[k];
            prim_v = pread_i[k] ? rd_val[pa] : '0;
            sec_v  = sread_i[k] ? rd_val[sa] : sec_i[k*DATA_W +: DATA_W];
            in_ready_o[k] = acc;
            if (acc && pwrite_i[k]) dest_mask[pa] = 1'b1;
            if (acc && asg) regs_d[pa] = sec_v;
            if (acc && pwrite_i[k] && !asg) busy_d[pa] = 1'b1;
            if (flush_i) out_valid_d[k] = 1'b0;
            else if (acc && !asg) begin
                out_valid_d[k]                   = 1'b1;
                out_wb_d[k]                      = pwrite_i[k];
                out_opcode_d[k*7 +: 7]           = opcode_i[k*7 +: 7];
                out_functype_d[k*2 +: 2]         = functype_i[k*2 +: 2];
                out_rd_d[k*ADDR_W +: ADDR_W]     = pa;
                out_prim_d[k*DATA_W +: DATA_W]   = prim_v;
                out_sec_d[k*DATA_W +: DATA_W]    = sec_v;
            end else if (out_ready_i[k]) out_valid_d[k] = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            busy_q         <= '0;
            out_valid_q    <= '0;
            out_wb_q       <= '0;
            out_opcode_q   <= '0;
            out_functype_q <= '0;
            out_rd_q       <= '0;
            out_prim_q     <= '0;
            out_sec_q      <= '0;
        end else begin
            regs_q         <= regs_d;
            busy_q         <= busy_d;
            out_valid_q    <= out_valid_d;
            out_wb_q       <= out_wb_d;
            out_opcode_q   <= out_opcode_d;
            out_functype_q <= out_functype_d;
            out_rd_q       <= out_rd_d;
            out_prim_q     <= out_prim_d;
            out_sec_q      <= out_sec_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_wb_o       = out_wb_q;
    assign out_opcode_o   = out_opcode_q;
    assign out_functype_o = out_functype_q;
    assign out_rd_o       = out_rd_q;
    assign out_prim_o     = out_prim_q;
    assign out_sec_o      = out_sec_q;
endmodule
